// File: rtl/reg_port_master_if.sv
// reg_port_master_if
//   Bundles every handshake and register-file signal of reg_port_master so
//   the initiator and its environment connect through one port.
//   Modports:
//     master - the reg_port_master side (drives read/write addresses,
//              operands toward execute, ins_ready and res_ready)
//     slave  - the environment side (decoder, register file, execute unit)
//   Signal groups:
//     ins_*     decoded instruction handshake (valid/ready, rs1/rs2/rd/rd_en)
//     readAdd*  register file read addresses, rf_out* read data
//     ex_*      operand issue handshake toward execute
//     res_*     in-order result handshake from execute
//     writeAdd/writeVal/wr  register file write port
//     pending_cnt  number of outstanding writebacks (0..DEPTH)
interface reg_port_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ins_valid;
  logic              ins_ready;
  logic [ADDR_W-1:0] ins_rs1;
  logic [ADDR_W-1:0] ins_rs2;
  logic [ADDR_W-1:0] ins_rd;
  logic              ins_rd_en;

  logic [ADDR_W-1:0] readAdd1;
  logic [ADDR_W-1:0] readAdd2;
  logic [DATA_W-1:0] rf_out1;
  logic [DATA_W-1:0] rf_out2;

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic              ex_wb;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_val;

  logic [ADDR_W-1:0] writeAdd;
  logic [DATA_W-1:0] writeVal;
  logic              wr;

  logic [CNT_W-1:0]  pending_cnt;

  modport master (
    input  ins_valid, ins_rs1, ins_rs2, ins_rd, ins_rd_en,
    output ins_ready,
    output readAdd1, readAdd2,
    input  rf_out1, rf_out2,
    output ex_valid, ex_op_a, ex_op_b, ex_wb,
    input  ex_ready,
    input  res_valid, res_val,
    output res_ready,
    output writeAdd, writeVal, wr,
    output pending_cnt
  );

  modport slave (
    output ins_valid, ins_rs1, ins_rs2, ins_rd, ins_rd_en,
    input  ins_ready,
    input  readAdd1, readAdd2,
    output rf_out1, rf_out2,
    input  ex_valid, ex_op_a, ex_op_b, ex_wb,
    output ex_ready,
    output res_valid, res_val,
    input  res_ready,
    input  writeAdd, writeVal, wr,
    input  pending_cnt
  );
endinterface

// File: rtl/reg_port_master.sv
// reg_port_master
//   Initiator side of the register-file read/write ports. Decoded
//   instructions drive the read addresses combinationally; the read data is
//   captured into a one-entry issue register toward execute. Results return
//   in issue order and are written back to the destination popped from a
//   FIFO of pending rd addresses. A per-register busy scoreboard stalls
//   issue on RAW/WAW hazards; there is no forwarding.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    reg_port_master_if.master (instruction, register file,
//            execute and result handshakes, pending_cnt)
module reg_port_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_port_master_if.master     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Scoreboard and pending-destination FIFO
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [ADDR_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Issue register
  logic                     ex_valid_q;
  logic                     ex_valid_d;
  logic signed [DATA_W-1:0] ex_op_a_q;
  logic signed [DATA_W-1:0] ex_op_b_q;
  logic                     ex_wb_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              hazard;
  logic              stage_free;
  logic              ins_ready;
  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(DEPTH));
  assign head       = fifo_q[rptr_q];

  // Only registered busy bits are consulted: a register written back this
  // cycle still reads as busy, so its readers wait one more cycle.
  assign hazard = busy_q[bus.ins_rs1] | busy_q[bus.ins_rs2] |
                  (bus.ins_rd_en & busy_q[bus.ins_rd]);

  assign stage_free = !ex_valid_q | bus.ex_ready;

  // Full FIFO blocks only writing instructions; ins_valid never feeds back.
  assign ins_ready = stage_free & !hazard & !(bus.ins_rd_en & fifo_full);
  assign accept    = bus.ins_valid & ins_ready;
  assign push      = accept & bus.ins_rd_en;
  assign pop       = bus.res_valid & !fifo_empty;

  // Set requires busy=0 and clear requires busy=1, so the two updates never
  // target the same bit in one cycle and their order here is irrelevant.
  always_comb begin
    busy_d = busy_q;
    if (pop)  busy_d[head]       = 1'b0;
    if (push) busy_d[bus.ins_rd] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A transfer with no new accept empties the stage; otherwise it holds.
  always_comb begin
    ex_valid_d = ex_valid_q;
    if (accept)              ex_valid_d = 1'b1;
    else if (bus.ex_ready)   ex_valid_d = 1'b0;
  end

  // ---- stage p0 -> p1: instruction accept / issue register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_op_a_q  <= '0;
      ex_op_b_q  <= '0;
      ex_wb_q    <= 1'b0;
      busy_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (accept) begin
        ex_op_a_q <= bus.rf_out1;
        ex_op_b_q <= bus.rf_out2;
        ex_wb_q   <= bus.ins_rd_en;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  // FIFO storage is qualified by the pointers/count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= bus.ins_rd;
  end

  assign bus.ins_ready   = ins_ready;
  assign bus.readAdd1    = bus.ins_rs1;
  assign bus.readAdd2    = bus.ins_rs2;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_op_a     = ex_op_a_q;
  assign bus.ex_op_b     = ex_op_b_q;
  assign bus.ex_wb       = ex_wb_q;
  assign bus.res_ready   = !fifo_empty;
  assign bus.wr          = pop;
  assign bus.writeAdd    = fifo_empty ? '0 : head;
  assign bus.writeVal    = bus.res_val;
  assign bus.pending_cnt = cnt_q;

endmodule

// File: doc/reg_port_master.md
Name: reg_port_master

Overview:
- Initiator side of the register-file read/write ports.
- Accepts decoded instructions (rs1/rs2/rd), drives the register file read addresses, and captures operands into a registered issue stage toward the execute unit.
- Takes in-order results back and drives the register file write port.
- A per-register busy scoreboard plus a FIFO of pending destination addresses stall issue on RAW/WAW hazards. No forwarding.

Parameters:
DATA_W  32  operand/result width; matches register file data width
ADDR_W  3  register address width
NREG  8  registers tracked by scoreboard; must equal 2**ADDR_W
DEPTH  4  max outstanding writebacks (pending-rd FIFO depth, power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ins_valid  in  1  instruction offered
ins_ready  out  1  instruction accepted this cycle when ins_valid & ins_ready
ins_rs1  in  ADDR_W  source register A
ins_rs2  in  ADDR_W  source register B
ins_rd  in  ADDR_W  destination register
ins_rd_en  in  1  instruction writes ins_rd
readAdd1  out  ADDR_W  register file read address 1
readAdd2  out  ADDR_W  register file read address 2
rf_out1  in  DATA_W  register file read data 1 (combinational from readAdd1)
rf_out2  in  DATA_W  register file read data 2
ex_valid  out  1  operands valid toward execute
ex_ready  in  1  execute accepts operands
ex_op_a  out  DATA_W  operand A
ex_op_b  out  DATA_W  operand B
ex_wb  out  1  this operation will return a result
res_valid  in  1  result offered (in issue order, only for ex_wb ops)
res_ready  out  1  result accepted
res_val  in  DATA_W  result data
writeAdd  out  ADDR_W  register file write address
writeVal  out  DATA_W  register file write data
wr  out  1  register file write enable
pending_cnt  out  log2(DEPTH)+1  outstanding writebacks

Behaviour:
- Reset (async, immediate): ex_valid=0, ex_op_a=ex_op_b=0, ex_wb=0, all busy bits=0, FIFO empty, pending_cnt=0. wr=0 and res_ready=0 while the FIFO is empty. ins_ready=1 after reset.
- Reset mid-operation discards in-flight operands and pending writebacks. Results arriving afterwards are not accepted (res_ready=0).
- Read addressing is combinational: readAdd1=ins_rs1, readAdd2=ins_rs2 at all times.
- Hazard = busy[rs1] | busy[rs2] | (ins_rd_en & busy[rd]). Uses registered busy bits only.
- stage_free = !ex_valid | ex_ready.
- ins_ready = stage_free & !hazard & !(ins_rd_en & fifo_full). Depends only on state, ex_ready and ins_* fields, not on ins_valid.
- Accept (ins_valid & ins_ready), registered on the next edge:
  - ex_op_a<=rf_out1, ex_op_b<=rf_out2, ex_wb<=ins_rd_en, ex_valid<=1.
  - If ins_rd_en: busy[rd]<=1 and rd is pushed to the FIFO.
  - Issue latency is 1 cycle.
- ex handshake: ex_valid/op/wb hold stable until ex_valid & ex_ready. A transfer with no new accept clears ex_valid. Back-to-back accept/transfer sustains 1 op/cycle.
- Writeback:
  - res_ready = !fifo_empty.
  - On res_valid & res_ready (combinational, same cycle): wr=1, writeAdd=FIFO head, writeVal=res_val. The register file captures at that edge.
  - Same edge: FIFO pop and busy[head]<=0.
  - When not writing: wr=0, writeAdd=FIFO head (or 0 if empty), writeVal=res_val.
- No forwarding: a reader of a register written this cycle stays stalled until the next cycle (busy clears at the edge). RAW stall is therefore minimum 1 cycle after writeback.
- Simultaneous push and pop: allowed, pending_cnt unchanged. Set and clear never hit the same busy bit, because set requires busy=0 and clear requires busy=1.
- Full: with DEPTH pending, rd_en instructions stall. Non-writing instructions still issue if hazard-free.
- FIFO pointers wrap modulo DEPTH. pending_cnt ranges 0..DEPTH.
- Same-register operands (rs1==rs2, or rs==rd) are legal. rs==rd with rd not busy issues normally.

Test Plan:
1. Reset, with RF preloaded r1=5, r2=7. Issue rs1=1, rs2=2, rd=3, rd_en=1, ex_ready=1 -> next cycle ex_valid=1, op_a=5, op_b=7, ex_wb=1, busy[3]=1, pending_cnt=1.
2. RAW: after test 1, offer rs1=3. Return res_val=12 -> ins_ready=0 until the cycle after wr=1 (writeAdd=3, writeVal=12); then the op issues with op_a=12.
3. Fill: issue 4 writes to rd=4..7 with res_valid=0 -> pending_cnt=4. A 5th rd_en op stalls, while a rd_en=0 op with free sources issues.
4. In-order writeback: drain results 0xA,0xB,0xC,0xD -> wr pulses with writeAdd 4,5,6,7 in order. pending_cnt returns to 0 and the FIFO pointers wrap correctly on a refill.
5. Backpressure: ex_ready=0 for 3 cycles -> ex_valid and operands held constant, ins_ready=0. On ex_ready=1, one transfer occurs and the next op is accepted the same cycle.
6. Assert reset with 2 pending writes and ex_valid=1 -> outputs return to reset values immediately. res_valid=1 afterwards produces no wr.
